oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL have parameter XFER_LEN, default 160, giving the number of bytes copied per DMA.
REQ-002 The block SHALL have parameter START_DELAY, default 1, giving the ce ticks between the register write and the first source read.
REQ-003 clk  in  1  single system clock.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 ce  in  1  CPU machine-cycle enable; all state advances only on clk edges with ce=1.
REQ-006 reg_wr  in  1  CPU write strobe to FF46, sampled with ce.
REQ-007 reg_di  in  8  CPU write data, used as the source page.
REQ-008 reg_do  out  8  FF46 readback, equal to the last written value.
REQ-009 dma_rd_addr  out  16  source read address.
REQ-010 dma_rd_data  in  8  source data, valid on the ce tick after dma_rd_addr was presented.
REQ-011 dma_active  out  1  OAM owned by DMA; the sprite unit gives DMA priority and returns FF to the CPU.
REQ-012 oam_wr  out  1  OAM write strobe, held for one ce period.
REQ-013 oam_addr  out  8  OAM byte index 0..XFER_LEN-1.
REQ-014 oam_di  out  8  OAM write data.

Function
REQ-015 States SHALL be IDLE, START, XFER and FLUSH.
- IDLE -> START on reg_wr.
- START lasts START_DELAY ticks, then -> XFER.
- XFER lasts XFER_LEN ticks, then -> FLUSH.
- FLUSH lasts 1 tick, then -> IDLE.
REQ-016 On reg_wr, src_page SHALL latch reg_di.
- If reg_di >= 0xE0, src_page SHALL latch reg_di - 0x20 (echo-RAM fold).
- reg_do SHALL return reg_di unmodified.
REQ-017 In XFER at byte index idx, dma_rd_addr SHALL equal {src_page, idx}; idx SHALL start at 0 and increment by 1 per ce tick.
REQ-018 On the ce tick after each XFER tick, outputs SHALL be oam_wr=1, oam_addr=idx of the previous tick and oam_di=dma_rd_data.
- This read/write pipeline SHALL be one stage deep.
- The FLUSH tick SHALL carry the write for idx=XFER_LEN-1.
REQ-019 dma_active SHALL be 1 throughout XFER and FLUSH and 0 in IDLE.
- Total high time is XFER_LEN+1 ce periods for an uninterrupted DMA.
REQ-020 dma_active SHALL be 0 during START when entered from IDLE.
REQ-021 A reg_wr during START, XFER or FLUSH SHALL restart the DMA:
- latch the new page;
- set idx=0;
- enter START;
- keep dma_active=1 during that START;
- still perform the pending OAM write of the interrupted byte on the next tick.
REQ-022 oam_wr SHALL be 0 whenever no write is pending; dma_rd_addr SHALL hold its last value in IDLE.
REQ-023 With ce=0, all outputs and state SHALL hold.
REQ-024 idx SHALL be 8 bits wide and SHALL never exceed XFER_LEN-1; no wrap-around into FEA0-FEFF.

Reset
REQ-025 reset_n=0 SHALL asynchronously force:
- state IDLE, idx 0, src_page 0x00;
- reg_do 0xFF;
- dma_active 0, oam_wr 0, oam_addr 0, oam_di 0, dma_rd_addr 0x0000.
REQ-026 Reset mid-transfer SHALL abort without any further OAM write; a restart requires a new reg_wr.

Structure
REQ-027 A shared package gb_dma_pkg SHALL hold:
- the state enum;
- XFER_LEN and START_DELAY defaults;
- the ECHO_FOLD threshold 0xE0.
REQ-028 The block SHALL be a single module with no sub-modules; the idx counter and write pipeline register are inline.

Verification
REQ-029 reg_wr with reg_di=0xC1, then full run ->
- dma_active high for exactly 161 ce periods;
- dma_rd_addr steps C100..C19F;
- OAM[i] equals source byte C100+i for all i.
REQ-030 reg_wr with reg_di=0xFE ->
- first dma_rd_addr=0xDE00;
- reg_do=0xFE.
REQ-031 reg_wr 0xC0, then at idx=50 reg_wr 0xD0 ->
- OAM[49] written from C031;
- dma_active stays 1 through the restart;
- next read is D000;
- final OAM[0..159] equals D000..D09F.
REQ-032 Toggle ce with 3 idle clocks between enables during XFER ->
- outputs hold between enables;
- final OAM contents identical to REQ-029.
REQ-033 Assert reset_n=0 at idx=80 ->
- dma_active, oam_wr and dma_rd_addr reach reset values immediately, without waiting for a clk edge;
- no OAM write occurs afterwards;
- reg_do=0xFF.

Source files
------------

// File: rtl/gb_dma_pkg.sv
// Shared definitions for the OAM DMA engine: state encoding, default sizing
// and the echo-RAM page fold.
package gb_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2,
    S_FLUSH = 2'd3
  } dma_state_e;

  localparam int         DEF_XFER_LEN    = 160;
  localparam int         DEF_START_DELAY = 1;
  localparam logic [7:0] ECHO_FOLD       = 8'hE0;

  // Pages E0-FF mirror C0-DF, so the DMA reads the underlying work RAM.
  function automatic logic [7:0] fold_page(input logic [7:0] page);
    return (page >= ECHO_FOLD) ? (page - 8'h20) : page;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to FF46 copies XFER_LEN bytes from {page, 00..}
// into sprite attribute memory, one byte per CPU machine cycle (ce).
module oam_dma
  import gb_dma_pkg::*;
#(
  parameter int XFER_LEN    = DEF_XFER_LEN,
  parameter int START_DELAY = DEF_START_DELAY
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        reg_wr,
  input  logic [7:0]  reg_di,
  output logic [7:0]  reg_do,
  output logic [15:0] dma_rd_addr,
  input  logic [7:0]  dma_rd_data,
  output logic        dma_active,
  output logic        oam_wr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_di,
  output dma_state_e  dbg_state
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);
  localparam logic [7:0] DLY_LAST = 8'(START_DELAY - 1);

  dma_state_e  state_q;
  logic [7:0]  dly_q;
  logic [7:0]  idx_q;
  logic [7:0]  page_q;
  logic [7:0]  reg_do_q;
  logic [15:0] rd_addr_q;
  logic        active_q;
  logic        oam_wr_q;
  logic [7:0]  oam_addr_q;
  logic [7:0]  oam_di_q;

  logic [7:0]  page_d;
  logic [7:0]  idx_d;

  assign page_d = fold_page(reg_di);
  assign idx_d  = idx_q + 8'd1;

  // Source/OAM timing contract: an address is presented for one ce period,
  // its data is taken from dma_rd_data at the closing ce edge, and the OAM
  // write (oam_wr/oam_addr/oam_di) is presented during the following period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      dly_q      <= '0;
      idx_q      <= '0;
      page_q     <= 8'h00;
      reg_do_q   <= 8'hFF;
      rd_addr_q  <= 16'h0000;
      active_q   <= 1'b0;
      oam_wr_q   <= 1'b0;
      oam_addr_q <= '0;
      oam_di_q   <= '0;
    end else if (ce) begin
      // Every XFER tick, including one cut short by a restart, retires its byte.
      oam_wr_q <= (state_q == S_XFER);
      if (state_q == S_XFER) begin
        oam_addr_q <= idx_q;
        oam_di_q   <= dma_rd_data;
      end

      if (reg_wr) begin
        reg_do_q <= reg_di;
        page_q   <= page_d;
        idx_q    <= '0;
        dly_q    <= '0;
        state_q  <= S_START;
        if (state_q == S_IDLE) begin
          active_q <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
          end
          S_START: begin
            if (dly_q == DLY_LAST) begin
              state_q   <= S_XFER;
              idx_q     <= '0;
              rd_addr_q <= {page_q, 8'h00};
              active_q  <= 1'b1;
            end else begin
              dly_q <= dly_q + 8'd1;
            end
          end
          S_XFER: begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_FLUSH;
            end else begin
              idx_q     <= idx_d;
              rd_addr_q <= {page_q, idx_d};
            end
          end
          S_FLUSH: begin
            state_q  <= S_IDLE;
            active_q <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign reg_do      = reg_do_q;
  assign dma_rd_addr = rd_addr_q;
  assign dma_active  = active_q;
  assign oam_wr      = oam_wr_q;
  assign oam_addr    = oam_addr_q;
  assign oam_di      = oam_di_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: per-cycle comparison against an elapsed-tick model,
// an OAM write scoreboard, a vector table and hand-written corner sequences.
module tb_oam_dma;
  import gb_dma_pkg::*;

  localparam int L = 160;
  localparam int D = 1;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        ce = 1'b0;
  logic        reg_wr = 1'b0;
  logic [7:0]  reg_di = 8'h00;
  logic [7:0]  reg_do;
  logic [15:0] dma_rd_addr;
  logic [7:0]  dma_rd_data;
  logic        dma_active;
  logic        oam_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_di;
  dma_state_e  dbg_state;

  logic [7:0]  src_mem [0:65535];
  logic [7:0]  oam_mem [0:255];
  int          wr_count = 0;

  assign dma_rd_data = src_mem[dma_rd_addr];

  oam_dma #(.XFER_LEN(L), .START_DELAY(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .reg_wr     (reg_wr),
    .reg_di     (reg_di),
    .reg_do     (reg_do),
    .dma_rd_addr(dma_rd_addr),
    .dma_rd_data(dma_rd_data),
    .dma_active (dma_active),
    .oam_wr     (oam_wr),
    .oam_addr   (oam_addr),
    .oam_di     (oam_di),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_n counts ce ticks since the last FF46 write: ticks [0,D) are START,
  // [D,D+L) transfer byte m_n-D, D+L is the flush tick, beyond is idle.
  bit          m_run  = 1'b0;
  int          m_n    = 0;
  logic [7:0]  m_page = 8'h00;
  bit          m_keep = 1'b0;
  logic [7:0]  exp_do = 8'hFF;
  logic        exp_act = 1'b0;
  logic        exp_wr = 1'b0;
  logic [15:0] exp_rd = 16'h0000;
  dma_state_e  exp_st = S_IDLE;
  logic [15:0] exp_q[$];

  task automatic model_reset();
    m_run = 1'b0; m_n = 0; m_page = 8'h00; m_keep = 1'b0;
    exp_do = 8'hFF; exp_act = 1'b0; exp_wr = 1'b0; exp_rd = 16'h0000; exp_st = S_IDLE;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic wr, input logic [7:0] di);
    bit was_x;
    int ci;
    was_x = m_run && (m_n >= D) && (m_n < D + L);
    ci = m_n - D;
    exp_wr = was_x;
    if (was_x) exp_q.push_back({8'(ci), src_mem[{m_page, 8'(ci)}]});
    if (wr) begin
      exp_do = di;
      m_keep = exp_act;
      m_page = (di >= 8'hE0) ? di - 8'h20 : di;
      m_n = 0;
      m_run = 1'b1;
    end else if (m_run && m_n <= D + L) begin
      m_n++;
    end
    if (!m_run) begin
      exp_act = 1'b0; exp_st = S_IDLE;
    end else if (m_n < D) begin
      exp_act = m_keep; exp_st = S_START;
    end else if (m_n < D + L) begin
      exp_act = 1'b1; exp_st = S_XFER; exp_rd = {m_page, 8'(m_n - D)};
    end else if (m_n == D + L) begin
      exp_act = 1'b1; exp_st = S_FLUSH;
    end else begin
      exp_act = 1'b0; exp_st = S_IDLE;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else if (ce) model_edge(reg_wr, reg_di);
  end

  // ---------------- OAM mirror + write scoreboard ----------------
  initial forever begin
    @(posedge clk);
    if (reset_n && ce && oam_wr) begin
      oam_mem[oam_addr] = oam_di;
      wr_count++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL oam_write_unexpected: got addr %0h data %0h, no write expected", oam_addr, oam_di);
      end else begin
        check("oam_write", {16'h0, oam_addr, oam_di}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("reg_do", 32'(reg_do), 32'(exp_do));
      check("dma_active", 32'(dma_active), 32'(exp_act));
      check("oam_wr", 32'(oam_wr), 32'(exp_wr));
      check("dma_rd_addr", 32'(dma_rd_addr), 32'(exp_rd));
      check("state", 32'(dbg_state), 32'(exp_st));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic c, input logic w, input logic [7:0] d);
    ce = c; reg_wr = w; reg_di = d;
    @(negedge clk);
  endtask

  task automatic wait_rd(input logic [15:0] a, input int budget);
    int k = 0;
    while (dma_rd_addr !== a && k < budget) begin
      step(1'b1, 1'b0, 8'h00);
      k++;
    end
    check("wait_rd_in_budget", 32'(k < budget), 32'd1);
  endtask

  task automatic check_oam(input string name, input logic [7:0] page);
    int bad = 0;
    for (int i = 0; i < L; i++)
      if (oam_mem[i] !== src_mem[{page, 8'(i)}]) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  di;
    logic [7:0]  exp_do;
    logic [15:0] exp_first_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int act_cnt;
    int wc0;
    logic [15:0] first_rd;
    logic c, w;
    logic [7:0] d;

    vecs[0] = '{8'hC1, 8'hC1, 16'hC100};
    vecs[1] = '{8'hFE, 8'hFE, 16'hDE00};
    vecs[2] = '{8'hE0, 8'hE0, 16'hC000};
    vecs[3] = '{8'hDF, 8'hDF, 16'hDF00};
    vecs[4] = '{8'hFF, 8'hFF, 16'hDF00};
    vecs[5] = '{8'h00, 8'h00, 16'h0000};

    for (int a = 0; a < 65536; a++) src_mem[a] = 8'($urandom_range(0, 255));

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_on = 1'b1;
    check("rst_reg_do", 32'(reg_do), 32'hFF);
    check("rst_active", 32'(dma_active), 32'd0);
    check("rst_oam_wr", 32'(oam_wr), 32'd0);
    check("rst_oam_addr", 32'(oam_addr), 32'd0);
    check("rst_oam_di", 32'(oam_di), 32'd0);
    check("rst_rd_addr", 32'(dma_rd_addr), 32'h0000);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // Vector table: page fold and readback, START inactive, first read address.
    for (int v = 0; v < 6; v++) begin
      step(1'b1, 1'b1, vecs[v].di);
      check("vec_reg_do", 32'(reg_do), 32'(vecs[v].exp_do));
      check("vec_start_inactive", 32'(dma_active), 32'd0);
      repeat (D) step(1'b1, 1'b0, 8'h00);
      check("vec_first_rd", 32'(dma_rd_addr), 32'(vecs[v].exp_first_rd));
      check("vec_xfer_active", 32'(dma_active), 32'd1);
      repeat (L + 2) step(1'b1, 1'b0, 8'h00);
    end

    // Full uninterrupted copy from C100.
    step(1'b1, 1'b1, 8'hC1);
    act_cnt = 0;
    first_rd = 16'hFFFF;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 8'h00);
      if (dma_active === 1'b1) begin
        if (act_cnt == 0) first_rd = dma_rd_addr;
        act_cnt++;
      end
    end
    check("full_active_periods", 32'(act_cnt), 32'(L + 1));
    check("full_first_rd", 32'(first_rd), 32'hC100);
    check_oam("full_oam_c1", 8'hC1);

    // Restart at idx 50 from page C0 to page D0.
    step(1'b1, 1'b1, 8'hC0);
    wait_rd(16'hC032, 100);
    step(1'b1, 1'b1, 8'hD0);
    check("restart_oam49", 32'(oam_mem[49]), 32'(src_mem[16'hC031]));
    check("restart_active", 32'(dma_active), 32'd1);
    check("restart_pending_wr", 32'(oam_wr), 32'd1);
    check("restart_pending_addr", 32'(oam_addr), 32'd50);
    repeat (D) step(1'b1, 1'b0, 8'h00);
    check("restart_first_rd", 32'(dma_rd_addr), 32'hD000);
    repeat (L + 5) step(1'b1, 1'b0, 8'h00);
    check_oam("restart_oam_d0", 8'hD0);

    // ce asserted once every four clocks; a reg_wr without ce must be ignored.
    step(1'b1, 1'b1, 8'hC1);
    for (int i = 0; i < L + 4; i++) begin
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h55);
      repeat (2) step(1'b0, 1'b0, 8'h00);
    end
    check_oam("ce_gap_oam_c1", 8'hC1);

    // Asynchronous reset at idx 80.
    step(1'b1, 1'b1, 8'hC0);
    wait_rd(16'hC050, 100);
    #2 reset_n = 1'b0;
    #1;
    wc0 = wr_count;
    check("async_rst_active", 32'(dma_active), 32'd0);
    check("async_rst_oam_wr", 32'(oam_wr), 32'd0);
    check("async_rst_rd_addr", 32'(dma_rd_addr), 32'h0000);
    check("async_rst_reg_do", 32'(reg_do), 32'hFF);
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) step(1'b1, 1'b0, 8'h00);
    check("no_write_after_reset", 32'(wr_count), 32'(wc0));
    check("idle_after_reset", 32'(dma_active), 32'd0);

    // Randomized traffic: sparse ce, occasional FF46 writes (some without ce).
    step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 3000; i++) begin
      c = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 119) == 0);
      d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(224, 255)) : 8'($urandom_range(0, 255));
      step(c, w, d);
    end
    repeat (L + 10) step(1'b1, 1'b0, 8'h00);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
